// File: rtl/bcd_serial_collector.sv
// bcd_serial_collector: assembles the serial BCD stream from the Excess-3
// converter (LSB first, 4 bits per digit) into parallel digits. Legal digits
// update Digit, the Disp history and the 7-segment pattern; digits above 9
// are dropped and counted in a saturating error counter.
module bcd_serial_collector #(
  parameter int NDIG = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Din,
  output logic [3:0]        Digit,
  output logic              Valid,
  output logic              Err,
  output logic [7:0]        ErrCnt,
  output logic [4*NDIG-1:0] Disp,
  output logic [6:0]        Seg
);

  logic [1:0]        cnt;
  logic [2:0]        sh;
  logic [3:0]        cand;
  logic              cand_legal;
  logic [4*NDIG-1:0] disp_next;

  // The fourth bit arrives live on Din; the first three were parked in sh.
  assign cand       = {Din, sh};
  assign cand_legal = (cand <= 4'd9);

  // The history shifts the new digit in at the low end. A one-digit history
  // has nothing to shift, so it simply takes the new digit.
  generate
    if (NDIG == 1) begin : g_disp_single
      assign disp_next = cand;
    end else begin : g_disp_shift
      assign disp_next = {Disp[4*NDIG-5:0], cand};
    end
  endgenerate

  // Bit framing: cnt free-runs with no enable, so framing is set only by reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= 2'd0;
      sh  <= 3'd0;
    end else begin
      cnt <= cnt + 2'd1;
      if (cnt != 2'd3) begin
        sh[cnt] <= Din;
      end
    end
  end

  // Digit completion: accept legal digits, count and drop the rest; pulses last one cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Digit  <= 4'd0;
      Valid  <= 1'b0;
      Err    <= 1'b0;
      ErrCnt <= 8'd0;
      Disp   <= '0;
    end else begin
      Valid <= 1'b0;
      Err   <= 1'b0;
      if (cnt == 2'd3) begin
        if (cand_legal) begin
          Digit <= cand;
          Valid <= 1'b1;
          Disp  <= disp_next;
        end else begin
          Err <= 1'b1;
          if (ErrCnt != 8'hFF) begin
            ErrCnt <= ErrCnt + 8'd1;
          end
        end
      end
    end
  end

  // 7-segment decode of the current digit, {g,f,e,d,c,b,a}, active-high.
  always_comb begin
    Seg = 7'b0000000;
    case (Digit)
      4'd0: Seg = 7'b0111111;
      4'd1: Seg = 7'b0000110;
      4'd2: Seg = 7'b1011011;
      4'd3: Seg = 7'b1001111;
      4'd4: Seg = 7'b1100110;
      4'd5: Seg = 7'b1101101;
      4'd6: Seg = 7'b1111101;
      4'd7: Seg = 7'b0000111;
      4'd8: Seg = 7'b1111111;
      4'd9: Seg = 7'b1101111;
      default: Seg = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_bcd_serial_collector.sv
// tb_bcd_serial_collector: directed serial digits with a scoreboard queue of
// expected completions; a negedge monitor pops and compares on every pulse.
`timescale 1ns/100ps
module tb_bcd_serial_collector;

  localparam int NDIG = 4;

  logic              Clk;
  logic              Rst;
  logic              Din;
  logic [3:0]        Digit;
  logic              Valid;
  logic              Err;
  logic [7:0]        ErrCnt;
  logic [4*NDIG-1:0] Disp;
  logic [6:0]        Seg;

  typedef struct {
    bit          isErr;
    logic [3:0]  digit;
    logic [7:0]  errCnt;
    logic [15:0] disp;
  } expT;

  expT expQ[$];

  int checks   = 0;
  int failures = 0;

  logic [3:0]  modelDigit;
  logic [7:0]  modelErrCnt;
  logic [15:0] modelDisp;

  bcd_serial_collector #(.NDIG(NDIG)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Din    (Din),
    .Digit  (Digit),
    .Valid  (Valid),
    .Err    (Err),
    .ErrCnt (ErrCnt),
    .Disp   (Disp),
    .Seg    (Seg)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hand-written segment table, independent of the design's decoder.
  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'd0: segOf = 7'b0111111;
      4'd1: segOf = 7'b0000110;
      4'd2: segOf = 7'b1011011;
      4'd3: segOf = 7'b1001111;
      4'd4: segOf = 7'b1100110;
      4'd5: segOf = 7'b1101101;
      4'd6: segOf = 7'b1111101;
      4'd7: segOf = 7'b0000111;
      4'd8: segOf = 7'b1111111;
      4'd9: segOf = 7'b1101111;
      default: segOf = 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " Digit"},  32'(Digit),  32'd0);
    checkOutput({tag, " Valid"},  32'(Valid),  32'd0);
    checkOutput({tag, " Err"},    32'(Err),    32'd0);
    checkOutput({tag, " ErrCnt"}, 32'(ErrCnt), 32'd0);
    checkOutput({tag, " Disp"},   32'(Disp),   32'd0);
    checkOutput({tag, " Seg"},    32'(Seg),    32'b0111111);
  endtask

  task automatic modelReset();
    checkOutput("no pending completion at reset", 32'(expQ.size()), 32'd0);
    expQ.delete();
    modelDigit  = 4'd0;
    modelErrCnt = 8'd0;
    modelDisp   = 16'd0;
  endtask

  // Drives one digit LSB first (one bit per rising edge) and queues the expected completion.
  task automatic applyStimulus(input logic [3:0] value);
    expT e;
    if (value <= 4'd9) begin
      modelDigit = value;
      modelDisp  = {modelDisp[11:0], value};
      e.isErr    = 1'b0;
    end else begin
      if (modelErrCnt != 8'hFF) modelErrCnt = modelErrCnt + 8'd1;
      e.isErr = 1'b1;
    end
    e.digit  = modelDigit;
    e.errCnt = modelErrCnt;
    e.disp   = modelDisp;
    expQ.push_back(e);
    for (int i = 0; i < 4; i++) begin
      Din = value[i];
      @(posedge Clk);
      #1;
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    expT e;
    if (Rst) begin
      if (Valid && Err) begin
        checkOutput("Valid and Err together", 32'({Valid, Err}), 32'b00);
      end else if (Valid || Err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected pulse", 32'({Valid, Err}), 32'b00);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulse kind Err",  32'(Err),    32'(e.isErr));
          checkOutput("pulse kind Valid", 32'(Valid), 32'(!e.isErr));
          checkOutput("Digit",  32'(Digit),  32'(e.digit));
          checkOutput("ErrCnt", 32'(ErrCnt), 32'(e.errCnt));
          checkOutput("Disp",   32'(Disp),   32'(e.disp));
          checkOutput("Seg",    32'(Seg),    32'(segOf(e.digit)));
        end
      end
    end
  end

  initial begin
    Din = 1'b0;
    Rst = 1'b0;
    modelDigit  = 4'd0;
    modelErrCnt = 8'd0;
    modelDisp   = 16'd0;
    #2;
    checkReset("power-on");

    // Held in reset across edges with Din toggling: nothing may move.
    for (int i = 0; i < 6; i++) begin
      Din = ~Din;
      @(posedge Clk);
      #1;
    end
    checkReset("held reset");
    Rst = 1'b1;

    // Legal digits 5,0,9,2.
    applyStimulus(4'd5);
    applyStimulus(4'd0);
    applyStimulus(4'd9);
    applyStimulus(4'd2);
    @(negedge Clk);
    checkOutput("Disp after 5092", 32'(Disp), 32'h5092);
    checkOutput("Seg after 5092",  32'(Seg),  32'b1011011);
    #1;

    // Illegal 13, then legal 3.
    applyStimulus(4'd13);
    applyStimulus(4'd3);

    // Mid-frame reset: two bits of a digit, then a 1 ns reset pulse.
    Din = 1'b1;
    @(posedge Clk); #1;
    Din = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    #0.5;
    checkReset("async reset");
    modelReset();
    #0.5;
    Rst = 1'b1;
    applyStimulus(4'd6);
    @(negedge Clk);
    checkOutput("Digit after mid-frame reset", 32'(Digit), 32'd6);
    #1;

    // Full legal sweep exercises every segment pattern.
    for (int v = 0; v < 10; v++) applyStimulus(4'(v));

    // 300 frames of 1111 saturate the error counter.
    for (int i = 0; i < 300; i++) applyStimulus(4'd15);
    @(negedge Clk);
    checkOutput("ErrCnt saturated", 32'(ErrCnt), 32'd255);
    checkOutput("Disp kept through errors", 32'(Disp), 32'h6789);
    #1;
    applyStimulus(4'd10);
    applyStimulus(4'd7);

    repeat (3) @(posedge Clk);
    #1;
    checkOutput("all completions seen", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
